// File: rtl/risc_v.sv
// risc_v: multicycle, non-pipelined RV32I subset core.
// Each instruction walks FETCH -> DECODE -> EXEC -> MEM -> WB, one state per
// clock, and leaves out the states it does not need. The instruction ROM,
// data RAM and register file are separate submodules whose arrays are
// preloaded and observed hierarchically; the core has no ports beyond clk/rst.
// Optional feature: define RISCV_JUMP_EN to enable jal/jalr. Without it,
// those opcodes execute as NOPs.

package risc_v_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [2:0] {CL_NOP, CL_ALU, CL_LUI, CL_LW, CL_SW, CL_BR, CL_JAL, CL_JALR} iclass_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
endpackage

// Instruction ROM: 256 words, combinational read. The load port is tied off
// by the core, so the contents come only from an external preload.
module risc_v_im (
    input  logic        clk,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic [7:0]  addr,
    output logic [31:0] data
);
    logic [31:0] rom [0:255];

    // Optional word load. Never enabled while the core runs.
    // NOTE: memory arrays are deliberately not reset, so preloaded contents survive rst and the array maps onto RAM.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (load_en) rom[load_addr] <= load_data;
    end

    assign data = rom[addr];
endmodule

// Data RAM: 256 words, combinational read, synchronous write.
module risc_v_dm (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] dmem [0:255];

    // Store port, used by sw in its MEM cycle.
    always_ff @(posedge clk) begin
        if (we) dmem[addr] <= wdata;
    end

    assign rdata = dmem[addr];
endmodule

// Register file: 32 x 32. x0 reads as zero and discards writes.
module risc_v_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [0:31];

    // Single write port. Reset clears every register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
endmodule

// Core FSM and datapath.
module risc_v
    import risc_v_pkg::*;
(
    input logic clk,
    input logic rst
);
    state_t      state;
    logic [31:0] pc, oldpc, ir, a, b, aluout, mdr;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u;
`ifdef RISCV_JUMP_EN
    logic [31:0] imm_j;
`endif
    iclass_t     iclass;
    logic [31:0] op2, alu_res;
    logic        br_taken;

    logic [31:0] im_data, rf_rd1, rf_rd2, rf_wd, dm_rdata;
    logic        rf_we, dm_we;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    // Immediates are built from IR, which stays stable from DECODE onwards.
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'd0};
`ifdef RISCV_JUMP_EN
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
`endif

    // Classify the latched instruction. Any opcode/funct not listed becomes a NOP.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        iclass = CL_NOP;
        case (opcode)
            OP_R: begin
                if ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 ||
                                              funct3 == 3'b100 || funct3 == 3'b010)) ||
                    (funct7 == 7'b0100000 && funct3 == 3'b000))
                    iclass = CL_ALU;
            end
            OP_I: begin
                if (funct3 != 3'b001 && funct3 != 3'b011 && funct3 != 3'b101) iclass = CL_ALU;
            end
            OP_LUI: iclass = CL_LUI;
            OP_LW:  if (funct3 == 3'b010) iclass = CL_LW;
            OP_SW:  if (funct3 == 3'b010) iclass = CL_SW;
            OP_BR:  if (funct3 == 3'b000 || funct3 == 3'b001) iclass = CL_BR;
`ifdef RISCV_JUMP_EN
            OP_JAL:  iclass = CL_JAL;
            OP_JALR: if (funct3 == 3'b000) iclass = CL_JALR;
`endif
            default: iclass = CL_NOP;
        endcase
    end

    // ALU for register/immediate forms and lui. slt compares signed.
    always_comb begin
        op2     = (opcode == OP_R) ? b : imm_i;
        alu_res = 32'd0;
        if (opcode == OP_LUI) begin
            alu_res = imm_u;
        end else begin
            case (funct3)
                3'b000:  alu_res = (opcode == OP_R && funct7[5]) ? a - op2 : a + op2;
                3'b111:  alu_res = a & op2;
                3'b110:  alu_res = a | op2;
                3'b100:  alu_res = a ^ op2;
                3'b010:  alu_res = {31'd0, ($signed(a) < $signed(op2))};
                default: alu_res = 32'd0;
            endcase
        end
    end

    assign br_taken = (funct3 == 3'b000) ? (a == b) : (a != b);

    // Register write: results land in WB. Jump links are written in EXEC.
    always_comb begin
        rf_we = 1'b0;
        rf_wd = aluout;
        if (state == WB) begin
            rf_we = (iclass == CL_ALU) || (iclass == CL_LUI) || (iclass == CL_LW);
            rf_wd = (iclass == CL_LW) ? mdr : aluout;
        end
`ifdef RISCV_JUMP_EN
        else if (state == EXEC && (iclass == CL_JAL || iclass == CL_JALR)) begin
            rf_we = 1'b1;
            rf_wd = oldpc + 32'd4;
        end
`endif
    end

    assign dm_we = (state == MEM) && (iclass == CL_SW);

    risc_v_im i_IM (
        .clk      (clk),
        .load_en  (1'b0),
        .load_addr(8'd0),
        .load_data(32'd0),
        .addr     (pc[9:2]),
        .data     (im_data)
    );

    risc_v_dm i_DM (
        .clk  (clk),
        .we   (dm_we),
        .addr (aluout[9:2]),
        .wdata(b),
        .rdata(dm_rdata)
    );

    risc_v_rf i_RF (
        .clk(clk),
        .rst(rst),
        .ra1(rs1),
        .ra2(rs2),
        .rd1(rf_rd1),
        .rd2(rf_rd2),
        .we (rf_we),
        .wa (rd),
        .wd (rf_wd)
    );

    // Instruction sequencer. Reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= 32'd0;
            oldpc  <= 32'd0;
            ir     <= 32'd0;
            a      <= 32'd0;
            b      <= 32'd0;
            aluout <= 32'd0;
            mdr    <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= im_data;
                    oldpc <= pc;
                    pc    <= pc + 32'd4;
                    state <= DECODE;
                end
                DECODE: begin
                    a     <= rf_rd1;
                    b     <= rf_rd2;
                    state <= EXEC;
                end
                EXEC: begin
                    case (iclass)
                        CL_ALU, CL_LUI: begin
                            aluout <= alu_res;
                            state  <= WB;
                        end
                        CL_LW: begin
                            aluout <= a + imm_i;
                            state  <= MEM;
                        end
                        CL_SW: begin
                            aluout <= a + imm_s;
                            state  <= MEM;
                        end
                        CL_BR: begin
                            if (br_taken) pc <= oldpc + imm_b;
                            state <= FETCH;
                        end
`ifdef RISCV_JUMP_EN
                        CL_JAL: begin
                            pc    <= oldpc + imm_j;
                            state <= FETCH;
                        end
                        CL_JALR: begin
                            pc    <= (a + imm_i) & ~32'd1;
                            state <= FETCH;
                        end
`endif
                        default: state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (iclass == CL_LW) begin
                        mdr   <= dm_rdata;
                        state <= WB;
                    end else begin
                        state <= FETCH;
                    end
                end
                WB:      state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_risc_v.sv
// tb_risc_v: self-checking bench for risc_v.
// Directed programs cover the reset state, the worked examples and abort on
// reset. Random programs run against an instruction-level interpreter. Its
// per-instruction results go into a scoreboard, and a monitor checks them
// every time the core returns to FETCH.
module tb_risc_v;
    import risc_v_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model state.
    logic [31:0] m_rom  [256];
    logic [31:0] m_mem  [256];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    // Scoreboard: one entry per retired instruction.
    int           exp_cyc_q  [$];
    logic [31:0]  exp_pc_q   [$];
    logic [1023:0] exp_regs_q [$];
    int           exp_idx_q  [$];
    logic [31:0]  exp_word_q [$];

    risc_v dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load(input int idx, input logic [31:0] w);
        m_rom[idx] = w;
        dut.i_IM.rom[idx] = w;
    endtask

    task automatic set_mem(input int idx, input logic [31:0] w);
        m_mem[idx] = w;
        dut.i_DM.dmem[idx] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            load(i, 32'd0);
            set_mem(i, $urandom());
        end
    endtask

    function automatic int nonzero_regs();
        int n = 0;
        for (int i = 0; i < 32; i++) if (dut.i_RF.regs[i] !== 32'd0) n++;
        return n;
    endfunction

    function automatic int dmem_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (dut.i_DM.dmem[i] !== m_mem[i]) n++;
        return n;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, " pc"},     dut.pc,     32'd0);
        check({tag, " oldpc"},  dut.oldpc,  32'd0);
        check({tag, " ir"},     dut.ir,     32'd0);
        check({tag, " a"},      dut.a,      32'd0);
        check({tag, " b"},      dut.b,      32'd0);
        check({tag, " aluout"}, dut.aluout, 32'd0);
        check({tag, " mdr"},    dut.mdr,    32'd0);
        check({tag, " state"},  32'(dut.state), 32'(FETCH));
        check({tag, " nonzero_regs"}, 32'(nonzero_regs()), 32'd0);
    endtask

    // ---------------- reference model (instruction level) ----------------
    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        logic [31:0] m = 32'hFFFF_FFFF << bits;
        return v[bits-1] ? (v | m) : (v & ~m);
    endfunction

    task automatic m_write(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) m_regs[rd] = v;
    endtask

    // Execute one instruction. Returns its cycle cost and the data word it touched.
    task automatic model_step(output int cyc, output int idx);
        logic [31:0] w, npc, r1, r2, ea, t, immi, imms, immb;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        bit          ok;
`ifdef RISCV_JUMP_EN
        logic [31:0] immj;
`endif
        w   = m_rom[m_pc[9:2]];
        op  = w[6:0];
        rd  = w[11:7];
        f3  = w[14:12];
        f7  = w[31:25];
        r1  = m_regs[w[19:15]];
        r2  = m_regs[w[24:20]];
        immi = sx({20'd0, w[31:20]}, 12);
        imms = sx({20'd0, w[31:25], w[11:7]}, 12);
        immb = sx({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
`ifdef RISCV_JUMP_EN
        immj = sx({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
`endif
        npc = m_pc + 32'd4;
        cyc = 3;
        idx = 0;
        ok  = 1'b1;
        t   = 32'd0;
        case (op)
            7'b0110011, 7'b0010011: begin
                r2 = (op == 7'b0110011) ? r2 : immi;
                if (op == 7'b0110011 && f7 == 7'h20) ok = (f3 == 3'd0);
                else if (op == 7'b0110011 && f7 != 7'h00) ok = 1'b0;
                if (ok) begin
                    case (f3)
                        3'd0: t = (op == 7'b0110011 && f7 == 7'h20) ? r1 - r2 : r1 + r2;
                        3'd7: t = r1 & r2;
                        3'd6: t = r1 | r2;
                        3'd4: t = r1 ^ r2;
                        3'd2: t = ($signed(r1) < $signed(r2)) ? 32'd1 : 32'd0;
                        default: ok = 1'b0;
                    endcase
                end
                if (ok) begin
                    m_write(rd, t);
                    cyc = 4;
                end
            end
            7'b0110111: begin
                m_write(rd, {w[31:12], 12'd0});
                cyc = 4;
            end
            7'b0000011: if (f3 == 3'd2) begin
                ea  = r1 + immi;
                idx = int'(ea[9:2]);
                m_write(rd, m_mem[idx]);
                cyc = 5;
            end
            7'b0100011: if (f3 == 3'd2) begin
                ea  = r1 + imms;
                idx = int'(ea[9:2]);
                m_mem[idx] = r2;
                cyc = 4;
            end
            7'b1100011: if (f3 == 3'd0 || f3 == 3'd1) begin
                if ((f3 == 3'd0) == (r1 == r2)) npc = m_pc + immb;
            end
`ifdef RISCV_JUMP_EN
            7'b1101111: begin
                m_write(rd, m_pc + 32'd4);
                npc = m_pc + immj;
            end
            7'b1100111: if (f3 == 3'd0) begin
                t = r1 + immi;
                m_write(rd, m_pc + 32'd4);
                npc = t & ~32'd1;
            end
`endif
            default: ;
        endcase
        m_pc = npc;
    endtask

    function automatic logic [1023:0] pack_model();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = m_regs[i];
        return v;
    endfunction

    // Random instruction mix over x0..x7, with undefined encodings mixed in.
    function automatic logic [31:0] gen_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [12:0] bo;
        logic [20:0] jo;
        int          o;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom());
        case ($urandom_range(0, 5))
            0:       f7 = 7'h20;
            1:       f7 = 7'h01;
            default: f7 = 7'h00;
        endcase
        case ($urandom_range(0, 10))
            0, 1: return {f7, rs2, rs1, f3, rd, 7'b0110011};
            2, 3: return {imm, rs1, f3, rd, 7'b0010011};
            4:    return {20'($urandom()), rd, 7'b0110111};
            5:    return {imm, rs1, ($urandom_range(0, 7) == 0) ? f3 : 3'd2, rd, 7'b0000011};
            6:    return {imm[11:5], rs2, rs1, ($urandom_range(0, 7) == 0) ? f3 : 3'd2, imm[4:0], 7'b0100011};
            7: begin
                o  = int'($urandom_range(0, 12)) - 4;
                bo = 13'(o * 4);
                return {bo[12], bo[10:5], rs2, rs1, ($urandom_range(0, 7) == 0) ? f3 : {2'd0, f3[0]},
                        bo[4:1], bo[11], 7'b1100011};
            end
            8: begin
                o  = int'($urandom_range(0, 16)) - 4;
                jo = 21'(o * 4);
                return {jo[20], jo[10:1], jo[11], jo[19:12], rd, 7'b1101111};
            end
            9:       return {imm, rs1, 3'd0, rd, 7'b1100111};
            default: return $urandom();
        endcase
    endfunction

    // Scoreboard monitor: an instruction has retired each time the core is back in FETCH.
    initial begin : monitor
        int            cyc;
        int            e_cyc, e_idx, bad;
        logic [31:0]   e_pc, e_word;
        logic [1023:0] e_regs;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                cyc = 0;
            end else begin
                cyc++;
                if (dut.state == FETCH && exp_cyc_q.size() > 0) begin
                    e_cyc  = exp_cyc_q.pop_front();
                    e_pc   = exp_pc_q.pop_front();
                    e_regs = exp_regs_q.pop_front();
                    e_idx  = exp_idx_q.pop_front();
                    e_word = exp_word_q.pop_front();
                    check("sb cycle", 32'(cyc), 32'(e_cyc));
                    check("sb pc", dut.pc, e_pc);
                    bad = 0;
                    for (int i = 31; i >= 0; i--)
                        if (dut.i_RF.regs[i] !== e_regs[i*32 +: 32]) bad = i;
                    check($sformatf("sb reg x%0d", bad), dut.i_RF.regs[bad], e_regs[bad*32 +: 32]);
                    check($sformatf("sb dmem[%0d]", e_idx), dut.i_DM.dmem[e_idx], e_word);
                end
            end
        end
    end

    task automatic run_random(input int n_instr, input int bound);
        int tot, c, idx, k;
        hold_reset();
        clear_mem();
        for (int i = 0; i < 256; i++) load(i, gen_instr());
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 32'd0;
        tot  = 0;
        exp_cyc_q.delete(); exp_pc_q.delete(); exp_regs_q.delete();
        exp_idx_q.delete(); exp_word_q.delete();
        for (int n = 0; n < n_instr; n++) begin
            model_step(c, idx);
            tot += c;
            exp_cyc_q.push_back(tot);
            exp_pc_q.push_back(m_pc);
            exp_regs_q.push_back(pack_model());
            exp_idx_q.push_back(idx);
            exp_word_q.push_back(m_mem[idx]);
        end
        @(negedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        k = 0;
        while (exp_cyc_q.size() > 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("sb pending", 32'(exp_cyc_q.size()), 32'd0);
        // Asynchronous reset between clock edges, while registers are live.
        #1;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset_state("async rst");
        check("dmem kept over rst", 32'(dmem_diffs()), 32'd0);
    endtask

    initial begin : stim
        // Power-on reset state.
        clear_mem();
        hold_reset();
        check_reset_state("por");

        // addi x1,5 ; addi x2,7 ; add x3,x1,x2 ; sw x3,4(x0)
        load(0, 32'h00500093);
        load(1, 32'h00700113);
        load(2, 32'h002081B3);
        load(3, 32'h00302223);
        set_mem(1, 32'hDEADBEEF);
        release_reset();
        cycles(3);  check("x1 before wb", dut.i_RF.regs[1], 32'd0);
        cycles(1);  check("x1 @4", dut.i_RF.regs[1], 32'd5);
        cycles(4);  check("x2 @8", dut.i_RF.regs[2], 32'd7);
        cycles(4);  check("x3 @12", dut.i_RF.regs[3], 32'd12);
        check("dmem[1] before sw", dut.i_DM.dmem[1], 32'hDEADBEEF);
        cycles(4);  check("dmem[1] @16", dut.i_DM.dmem[1], 32'd12);
        check("pc @16", dut.pc, 32'd16);

        // lw x4,0(x0)
        hold_reset();
        clear_mem();
        load(0, 32'h00002203);
        set_mem(0, 32'h0000002A);
        release_reset();
        cycles(4);  check("x4 @4", dut.i_RF.regs[4], 32'd0);
        cycles(1);  check("x4 @5", dut.i_RF.regs[4], 32'h2A);
        check("lw pc @5", dut.pc, 32'd4);

        // beq x0,x0,0 spins at PC 0 with no side effects
        hold_reset();
        clear_mem();
        load(0, 32'h00000063);
        release_reset();
        cycles(1);  check("beq pc @1", dut.pc, 32'd4);
        cycles(2);  check("beq pc @3", dut.pc, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycles(3);
            check($sformatf("beq pc loop %0d", i), dut.pc, 32'd0);
        end
        check("beq regs", 32'(nonzero_regs()), 32'd0);
        check("beq dmem", 32'(dmem_diffs()), 32'd0);

        // Reset during WB of addi x1,x0,5 aborts the write.
        hold_reset();
        clear_mem();
        load(0, 32'h00500093);
        release_reset();
        cycles(3);
        check("state is wb", 32'(dut.state), 32'(WB));
        #1 rst = 1'b1;
        #1;
        check("abort x1", dut.i_RF.regs[1], 32'd0);
        check("abort pc", dut.pc, 32'd0);
        release_reset();
        cycles(4);  check("rerun x1", dut.i_RF.regs[1], 32'd5);

        // jal x1,8
        hold_reset();
        clear_mem();
        load(0, 32'h008000EF);
        release_reset();
        cycles(3);
`ifdef RISCV_JUMP_EN
        check("jal x1", dut.i_RF.regs[1], 32'd4);
        check("jal pc", dut.pc, 32'd8);
`else
        check("jal-nop x1", dut.i_RF.regs[1], 32'd0);
        check("jal-nop pc", dut.pc, 32'd4);
`endif

        // Random programs against the reference model.
        run_random(250, 3000);
        run_random(250, 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
